// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: data width, default RX FIFO depth,
// and ASCII codes used across the UART path.
package uart_rx_fifo_pkg;

  localparam int DATA_BITS         = 8;
  localparam int RX_FIFO_ADDR_BITS = 2;

  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_PLUS  = 8'd43;
  localparam logic [7:0] ASCII_MINUS = 8'd45;

endpackage

// File: rtl/uart_rx_fifo_ctrl.sv
// RX FIFO control: read/write pointers, next-pointer logic
// and the registered EMPTY/FULL flags.
module uart_rx_fifo_ctrl
  import uart_rx_fifo_pkg::*;
#(
  parameter int W = RX_FIFO_ADDR_BITS
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_i,
  input  logic         rd_i,
  output logic         we_o,
  output logic [W-1:0] wr_ptr_o,
  output logic [W-1:0] rd_ptr_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] wr_ptr_q, wr_ptr_d;
  logic [W-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0] wr_nxt, rd_nxt;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         we, re;

  assign wr_nxt = wr_ptr_q + W'(1);
  assign rd_nxt = rd_ptr_q + W'(1);

  // When full, a same-cycle pop frees the slot the write lands in.
  assign we = wr_i & (~full_q | rd_i);
  assign re = rd_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    empty_d  = empty_q;
    full_d   = full_q;
    unique case ({we, re})
      2'b11: begin
        wr_ptr_d = wr_nxt;
        rd_ptr_d = rd_nxt;
      end
      2'b10: begin
        wr_ptr_d = wr_nxt;
        empty_d  = 1'b0;
        full_d   = (wr_nxt == rd_ptr_q);
      end
      2'b01: begin
        rd_ptr_d = rd_nxt;
        full_d   = 1'b0;
        empty_d  = (rd_nxt == wr_ptr_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign we_o     = we;
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign empty_o  = empty_q;
  assign full_o   = full_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO, first-word-fall-through read port.
// Define RX_FIFO_OVF_EN to add a sticky OVERFLOW output.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int B = DATA_BITS,
  parameter int W = RX_FIFO_ADDR_BITS
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         WR,
  input  logic [B-1:0] W_DATA,
  input  logic         RD,
  output logic [B-1:0] R_DATA,
  output logic         EMPTY,
  output logic         FULL
`ifdef RX_FIFO_OVF_EN
  ,
  output logic         OVERFLOW
`endif
);

  logic [B-1:0] mem_q [2**W];
  logic [W-1:0] wr_ptr, rd_ptr;
  logic         we;

  uart_rx_fifo_ctrl #(.W(W)) u_ctrl (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .wr_i    (WR),
    .rd_i    (RD),
    .we_o    (we),
    .wr_ptr_o(wr_ptr),
    .rd_ptr_o(rd_ptr),
    .empty_o (EMPTY),
    .full_o  (FULL)
  );

  always_ff @(posedge CLK) begin
    if (we) mem_q[wr_ptr] <= W_DATA;
  end

  assign R_DATA = mem_q[rd_ptr];

`ifdef RX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (WR & FULL & ~RD);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign OVERFLOW = ovf_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Builds with or without RX_FIFO_OVF_EN.
module tb_uart_rx_fifo;

  logic       CLK;
  logic       RESET;
  logic       WR;
  logic [7:0] W_DATA;
  logic       RD;
  logic [7:0] R_DATA;
  logic       EMPTY;
  logic       FULL;
`ifdef RX_FIFO_OVF_EN
  logic       OVERFLOW;
`endif

  int tests;
  int fails;

  uart_rx_fifo dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .WR      (WR),
    .W_DATA  (W_DATA),
    .RD      (RD),
    .R_DATA  (R_DATA),
    .EMPTY   (EMPTY),
`ifdef RX_FIFO_OVF_EN
    .OVERFLOW(OVERFLOW),
`endif
    .FULL    (FULL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    WR = 1'b1;
    W_DATA = d;
    tick();
    WR = 1'b0;
  endtask

  task automatic pop();
    RD = 1'b1;
    tick();
    RD = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    tests++;
    if (EMPTY !== 1'b1) begin
      fails++;
      $display("FAIL reset_empty: got %b want 1", EMPTY);
    end
    tests++;
    if (FULL !== 1'b0) begin
      fails++;
      $display("FAIL reset_full: got %b want 0", FULL);
    end
`ifdef RX_FIFO_OVF_EN
    tests++;
    if (OVERFLOW !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: got %b want 0", OVERFLOW);
    end
`endif
    pop();
    pop();
    tests++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
      fails++;
      $display("FAIL rd_on_empty: empty=%b full=%b want 1 0",
               EMPTY, FULL);
    end
  endtask

  task automatic test_single();
    push(8'd55);
    tests++;
    if (EMPTY !== 1'b0 || R_DATA !== 8'd55) begin
      fails++;
      $display("FAIL single_wr: empty=%b data=%0d want 0 55",
               EMPTY, R_DATA);
    end
    pop();
    tests++;
    if (EMPTY !== 1'b1) begin
      fails++;
      $display("FAIL single_rd: empty=%b want 1", EMPTY);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp [4];
    exp = '{8'd55, 8'd53, 8'd45, 8'd51};
    for (int i = 0; i < 4; i++) begin
      push(exp[i]);
      tests++;
      if (FULL !== (i == 3) || EMPTY !== 1'b0) begin
        fails++;
        $display("FAIL fill_%0d: full=%b empty=%b want %b 0",
                 i, FULL, EMPTY, (i == 3));
      end
    end
    push(8'd13);
    tests++;
    if (FULL !== 1'b1) begin
      fails++;
      $display("FAIL drop_full: got %b want 1", FULL);
    end
`ifdef RX_FIFO_OVF_EN
    tests++;
    if (OVERFLOW !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: got %b want 1", OVERFLOW);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (R_DATA !== exp[i] || EMPTY !== 1'b0) begin
        fails++;
        $display("FAIL drain_%0d: data=%0d empty=%b want %0d 0",
                 i, R_DATA, EMPTY, exp[i]);
      end
      pop();
    end
    tests++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
      fails++;
      $display("FAIL drained: empty=%b full=%b want 1 0",
               EMPTY, FULL);
    end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 6; i++) begin
      push(8'(i));
      tests++;
      if (R_DATA !== 8'(i) || EMPTY !== 1'b0 || FULL !== 1'b0) begin
        fails++;
        $display("FAIL wrap_wr_%0d: data=%0d e=%b f=%b want %0d 0 0",
                 i, R_DATA, EMPTY, FULL, i);
      end
      pop();
      tests++;
      if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
        fails++;
        $display("FAIL wrap_rd_%0d: e=%b f=%b want 1 0",
                 i, EMPTY, FULL);
      end
    end
  endtask

  task automatic test_simul();
    logic [7:0] exp [4];
    exp = '{8'd53, 8'd45, 8'd51, 8'd13};
    WR = 1'b1;
    RD = 1'b1;
    W_DATA = 8'd13;
    tick();
    WR = 1'b0;
    RD = 1'b0;
    tests++;
    if (EMPTY !== 1'b0 || R_DATA !== 8'd13) begin
      fails++;
      $display("FAIL simul_empty: empty=%b data=%0d want 0 13",
               EMPTY, R_DATA);
    end
    pop();
    tests++;
    if (EMPTY !== 1'b1) begin
      fails++;
      $display("FAIL simul_empty_rd: empty=%b want 1", EMPTY);
    end
    push(8'd55);
    push(8'd53);
    push(8'd45);
    push(8'd51);
    WR = 1'b1;
    RD = 1'b1;
    W_DATA = 8'd13;
    tick();
    WR = 1'b0;
    RD = 1'b0;
    tests++;
    if (FULL !== 1'b1) begin
      fails++;
      $display("FAIL simul_full: full=%b want 1", FULL);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (R_DATA !== exp[i] || EMPTY !== 1'b0) begin
        fails++;
        $display("FAIL simul_drain_%0d: data=%0d empty=%b want %0d 0",
                 i, R_DATA, EMPTY, exp[i]);
      end
      pop();
    end
    tests++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
      fails++;
      $display("FAIL simul_drained: e=%b f=%b want 1 0", EMPTY, FULL);
    end
  endtask

  task automatic test_async_reset();
    push(8'd1);
    push(8'd2);
    push(8'd3);
    tests++;
    if (EMPTY !== 1'b0) begin
      fails++;
      $display("FAIL ar_pre: empty=%b want 0", EMPTY);
    end
    #2;
    RESET = 1'b0;
    #1;
    tests++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
      fails++;
      $display("FAIL ar_async: e=%b f=%b want 1 0", EMPTY, FULL);
    end
`ifdef RX_FIFO_OVF_EN
    tests++;
    if (OVERFLOW !== 1'b0) begin
      fails++;
      $display("FAIL ar_ovf: got %b want 0", OVERFLOW);
    end
`endif
    #2;
    RESET = 1'b1;
    tick();
    push(8'd51);
    tests++;
    if (R_DATA !== 8'd51 || EMPTY !== 1'b0) begin
      fails++;
      $display("FAIL ar_first: data=%0d empty=%b want 51 0",
               R_DATA, EMPTY);
    end
    pop();
    tests++;
    if (EMPTY !== 1'b1) begin
      fails++;
      $display("FAIL ar_drain: empty=%b want 1", EMPTY);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESET = 1'b0;
    WR = 1'b0;
    RD = 1'b0;
    W_DATA = 8'd0;
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_simul();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART receiver and the receive interface FSM that feeds the ALU handler. Captures each byte the receiver flags with a one-cycle done tick. Presents the oldest byte first-word-fall-through, with an empty flag and a read strobe that matches the interface FSM handshake. Decouples receiver byte timing from interface FSM consumption.

Parameters:
B, 8, data width in bits
W, 2, address width; depth = 2**W entries (default 4)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous reset, active-low (0 = reset)
WR  input  1  write strobe; one-cycle rx_done tick from the UART receiver
W_DATA  input  B  byte from the receiver, valid when WR=1
RD  input  1  read/pop strobe from the interface FSM (its RD_FIFO)
R_DATA  output  B  oldest stored byte (FWFT), valid while EMPTY=0
EMPTY  output  1  no bytes stored; drives the interface FSM FIFO_empty
FULL  output  1  2**W bytes stored

Behaviour:
- Storage: 2**W x B register array. Write pointer wr_ptr and read pointer rd_ptr are W bits wide and wrap naturally modulo 2**W. Full and empty registers are kept separately, with no extra pointer bit.
- Reset (RESET=0, asynchronous): wr_ptr=0, rd_ptr=0, EMPTY=1, FULL=0. Array contents are not reset. R_DATA shows mem[0], which is don't-care while EMPTY=1.
- R_DATA = mem[rd_ptr], combinational from the array. No read latency: data is valid in the same cycle EMPTY is 0.
- Write only (WR=1, RD=0):
  - if FULL: write dropped, no state change.
  - else: mem[wr_ptr]<=W_DATA; wr_ptr+1; EMPTY<=0; FULL<=1 if wr_ptr+1==rd_ptr.
- Read only (WR=0, RD=1):
  - if EMPTY: ignored, no state change.
  - else: rd_ptr+1; FULL<=0; EMPTY<=1 if rd_ptr+1==wr_ptr.
- Write and read in the same cycle (WR=1, RD=1):
  - EMPTY: the write proceeds as a write-only and the read is ignored. EMPTY falls next cycle; the byte is not bypassed.
  - FULL: both proceed. The oldest byte is popped and the new byte is stored in the freed slot; FULL stays 1.
  - otherwise: both pointers advance; EMPTY and FULL are unchanged.
- Flags are registered and update on the clock edge after the causing strobe. EMPTY and FULL are never 1 together.
- RD is edge-agnostic: each cycle with RD=1 and EMPTY=0 pops exactly one byte. The interface FSM asserts RD for exactly one cycle per byte.
- Pointer wrap: after 2**W writes, wr_ptr returns to 0. Ordering is strictly FIFO across the wrap.
- Reset mid-operation: all stored bytes are discarded and EMPTY=1 asynchronously. No partial write completes.

Optional Feature:
Macro RX_FIFO_OVF_EN.
- Defined: adds output OVERFLOW (1 bit, reset 0).
  - Set on the edge after any cycle with WR=1, FULL=1 and RD=0 (a dropped byte).
  - Sticky until RESET=0.
  - The dropped byte still does not enter the array.
- Not defined: no OVERFLOW port and no related logic. Overflow writes are silently dropped.

Decomposition:
- Shared UART package holds:
  - data width constant DATA_BITS=8, used for B
  - default FIFO address width constant RX_FIFO_ADDR_BITS=2
  - ASCII constants used across the UART path: CR=13, '+'=43, '-'=45
- One natural sub-module, fifo_ctrl: pointers, next-pointer logic, and the EMPTY/FULL registers, with write-enable out.
- The top level holds the register array and the read mux.

Test Plan:
- Reset with RESET=0, then release → EMPTY=1, FULL=0. RD pulses have no effect: EMPTY stays 1 and pointers stay 0.
- Write 55 ('7') with a single WR tick → next cycle EMPTY=0, R_DATA=55. One RD pulse → next cycle EMPTY=1.
- Write 55, 53, 45, 51 with no reads → FULL=1 after the 4th. Write 13: it is dropped, FULL stays 1, and OVERFLOW=1 if RX_FIFO_OVF_EN is defined. Four RD pulses yield R_DATA 55, 53, 45, 51 in order, then EMPTY=1.
- Wrap: 6 rounds of write-then-read, bytes 1..6 → each byte appears on R_DATA in order with no loss. The pointers wrap past 3 without a spurious FULL or EMPTY.
- Simultaneous WR and RD:
  - on empty, write 13 with RD=1 → next cycle EMPTY=0, R_DATA=13.
  - on full (55, 53, 45, 51), WR=1 with W_DATA=13 and RD=1 → FULL stays 1; the read sequence is 53, 45, 51, 13.
- Async reset while holding 3 bytes: RESET=0 mid-cycle → EMPTY=1 and FULL=0 immediately, without waiting for a clock edge. After release, the first new write, 51, is the first byte read.
